apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
APB requester that sits directly upstream of the team's APB slave memory (APB_V2). It converts a simple valid/ready request port into APB SETUP/ACCESS phases on psel/penable/pwrite/paddr/pwdata. It samples pready/prdata and returns a one-cycle response pulse with read data or a timeout error. There is one transfer outstanding at a time; back-to-back transfers run without an IDLE gap.

Parameters:
ADDR_WIDTH, 2, width of paddr/req_addr; matches the slave's address width.
DATA_WIDTH, 4, width of pwdata/prdata/req_wdata/rsp_rdata.
TIMEOUT, 16, number of consecutive ACCESS cycles with pready=0 before the transfer is aborted; 0 disables the timeout.
TO_WIDTH, 8, width of the wait counter; TIMEOUT must be less than 2**TO_WIDTH.

Ports:
pclk  input  1  clock; all state changes on the rising edge
prst  input  1  reset; synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  request accepted on this edge when req_valid=1
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  transfer address
req_wdata  input  DATA_WIDTH  write data; ignored for reads
rsp_valid  output  1  one-cycle completion pulse
rsp_err  output  1  qualifies rsp_valid; 1=timeout abort
rsp_rdata  output  DATA_WIDTH  read data; valid when rsp_valid=1, rsp_err=0, and the transfer was a read
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
pready  input  1  slave ready
prdata  input  DATA_WIDTH  slave read data

Behaviour:
- One clock, pclk. Reset prst is synchronous and active-high. While prst=1 at an edge: state=IDLE, wait counter=0, and all outputs 0 next cycle (psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata). prst has priority over every other event.
- FSM states: IDLE, SETUP, ACCESS.
  - psel = (state != IDLE).
  - penable = (state == ACCESS).
  - Both are decoded from the state register only; no combinational path from any input to psel/penable.
- req_ready is combinational: 1 in IDLE; 1 in ACCESS when pready=1 or the timeout fires this cycle; 0 otherwise (including all of SETUP).
- Accept (req_valid and req_ready at an edge):
  - req_write/req_addr/req_wdata are registered onto pwrite/paddr/pwdata.
  - Next state is SETUP.
- IDLE: with no request, stay in IDLE. paddr/pwrite/pwdata hold their last values.
- SETUP: lasts exactly 1 cycle, then ACCESS unconditionally. The wait counter clears to 0.
- ACCESS:
  - paddr/pwrite/pwdata are stable from SETUP through the last ACCESS cycle.
  - pready=1 at the edge (completion):
    - rsp_valid=1 and rsp_err=0 for the following cycle.
    - On reads, rsp_rdata <= prdata. On writes, rsp_rdata holds its value.
    - Next state is SETUP if req_valid=1 (new request accepted on the same edge), else IDLE.
  - pready=0 and (TIMEOUT==0 or counter < TIMEOUT-1): counter increments; stay in ACCESS.
  - pready=0 and TIMEOUT!=0 and counter == TIMEOUT-1 (the TIMEOUT-th wait cycle):
    - Abort: rsp_valid=1, rsp_err=1; rsp_rdata unchanged.
    - Next state follows the same SETUP/IDLE rule as completion.
- Latency with a zero-wait slave: accept at edge N; SETUP in cycle N..N+1; ACCESS from N+1; completion sampled at edge N+2; rsp_valid high in cycle N+2..N+3. Each transfer occupies 2 bus cycles; the back-to-back rate is 1 transfer per 2 cycles.
- rsp_valid/rsp_err are registered, high for exactly 1 cycle per transfer, and otherwise 0. rsp_err=0 whenever rsp_valid=0.
- Counter saturation: the counter never exceeds TIMEOUT-1. With TIMEOUT=0 the counter saturates at 2**TO_WIDTH-1 and ACCESS persists until pready.
- Reset mid-transfer (prst=1 in SETUP or ACCESS): psel/penable drop to 0 next cycle; no rsp_valid for the aborted transfer; the request is lost.
- The pready value in IDLE or SETUP is ignored.

Test Plan:
1. Write then read, zero-wait slave (pready tied 1 in ACCESS). Write addr=2, wdata=4'hA, then read addr=2 with the slave returning 4'hA. Expect: psel 2 cycles per transfer, penable only in the 2nd cycle; rsp_valid pulse with rsp_err=0 and rsp_rdata=4'hA after the read only.
2. Back-to-back: req_valid held high for writes to addr 0,1,2,3 (data 1,2,3,4). Expect: psel continuously 1 for 8 cycles, penable toggling 0,1,0,1,…, paddr 0..3 each held for 2 cycles, 4 rsp_valid pulses, req_ready=0 in every SETUP cycle.
3. Wait states: read addr=1, slave holds pready=0 for 3 ACCESS cycles then returns 4'h5. Expect: penable=1 for 4 cycles with paddr stable; rsp_valid one cycle after pready; rsp_rdata=5, rsp_err=0.
4. Timeout, TIMEOUT=4, pready stuck 0. Expect: penable=1 for exactly 4 cycles, then rsp_valid=1 and rsp_err=1, rsp_rdata unchanged, return to IDLE (psel=0); a following normal transfer completes correctly.
5. Reset mid-ACCESS: assert prst for 1 cycle during the wait of scenario 3. Expect: all outputs 0 the cycle after the reset edge, no rsp_valid, and the next request runs from SETUP normally.
6. Request stability: change req_addr/req_wdata during SETUP/ACCESS with req_valid=1. Expect: paddr/pwdata unchanged until completion; the new values are captured only on the completion edge.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready request port into APB SETUP/ACCESS
// phases and returns a one-cycle response pulse (read data or timeout).
module apb_master #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam logic [TO_WIDTH-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : TO_WIDTH'(TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0] CNT_MAX = '1;

    state_e                state_q;
    logic [TO_WIDTH-1:0]   cnt_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic timeout_fire;
    logic accept;

    // Abort condition and request handshake, valid for the current cycle
    always_comb begin
        timeout_fire = (TIMEOUT != 0) && (state_q == ACCESS) &&
                       !pready && (cnt_q == TO_LAST);
        req_ready = (state_q == IDLE) ||
                    ((state_q == ACCESS) && (pready || timeout_fire));
        accept = req_valid && req_ready;
    end

    // Transfer FSM with registered bus and response outputs
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (accept) begin
                pwrite_q <= req_write;
                paddr_q  <= req_addr;
                pwdata_q <= req_wdata;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_valid) state_q <= SETUP;
                end
                SETUP: begin
                    cnt_q   <= '0;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid_q <= 1'b1;
                        if (!pwrite_q) rsp_rdata_q <= prdata;
                        state_q <= req_valid ? SETUP : IDLE;
                    end else if (timeout_fire) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q <= req_valid ? SETUP : IDLE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): zero-wait, back-to-back,
// wait states, timeout, mid-transfer reset and request stability.
module tb_apb_master;

    logic       pclk;
    logic       prst;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [3:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_err;
    logic [3:0] rsp_rdata;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [1:0] paddr;
    logic [3:0] pwdata;
    logic       pready;
    logic [3:0] prdata;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    apb_master #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(4),
        .TIMEOUT(4),
        .TO_WIDTH(8)
    ) dut (
        .pclk(pclk),
        .prst(prst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .pready(pready),
        .prdata(prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        prst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        pready = 1'b0;
        prdata = '0;
        tick();
        tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        prst = 1'b0;
        #1;
        chk("idle_ready", req_ready, 1);

        // 1: write addr 2 = A, then read it back, zero-wait
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 2'd2; req_wdata = 4'hA; pready = 1'b1;
        tick();
        chk("w_setup_psel", psel, 1);
        chk("w_setup_pen", penable, 0);
        chk("w_setup_paddr", paddr, 2);
        chk("w_setup_pwdata", pwdata, 4'hA);
        chk("w_setup_pwrite", pwrite, 1);
        chk("w_setup_ready", req_ready, 0);
        req_valid = 1'b0;
        tick();
        chk("w_access_pen", penable, 1);
        chk("w_access_ready", req_ready, 1);
        tick();
        chk("w_rsp_valid", rsp_valid, 1);
        chk("w_rsp_err", rsp_err, 0);
        chk("w_rdata_hold", rsp_rdata, 0);
        chk("w_idle_psel", psel, 0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
        tick();
        chk("r_setup_pwrite", pwrite, 0);
        chk("r_no_rsp", rsp_valid, 0);
        req_valid = 1'b0; prdata = 4'hA;
        tick();
        chk("r_access_pen", penable, 1);
        tick();
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_err", rsp_err, 0);
        chk("r_rdata", rsp_rdata, 4'hA);
        tick();
        chk("r_pulse_1cyc", rsp_valid, 0);

        // 2: back-to-back writes to 0..3
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 2'd0; req_wdata = 4'd1; pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) pulses++;
            chk($sformatf("b2b_setup_psel%0d", i), psel, 1);
            chk($sformatf("b2b_setup_pen%0d", i), penable, 0);
            chk($sformatf("b2b_setup_paddr%0d", i), paddr, i);
            chk($sformatf("b2b_setup_ready%0d", i), req_ready, 0);
            if (i < 3) begin
                req_addr = 2'(i + 1);
                req_wdata = 4'(i + 2);
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (rsp_valid) pulses++;
            chk($sformatf("b2b_acc_psel%0d", i), psel, 1);
            chk($sformatf("b2b_acc_pen%0d", i), penable, 1);
            chk($sformatf("b2b_acc_paddr%0d", i), paddr, i);
            chk($sformatf("b2b_acc_pwdata%0d", i), pwdata, i + 1);
        end
        tick();
        if (rsp_valid) pulses++;
        chk("b2b_pulses", pulses, 4);
        chk("b2b_idle", psel, 0);

        // 3: read addr 1 with 3 wait states, returns 5
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; pready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ws_pen%0d", k), penable, 1);
            chk($sformatf("ws_paddr%0d", k), paddr, 1);
            chk($sformatf("ws_ready%0d", k), req_ready, 0);
            chk($sformatf("ws_norsp%0d", k), rsp_valid, 0);
            tick();
        end
        pready = 1'b1; prdata = 4'h5;
        #1;
        chk("ws_last_pen", penable, 1);
        chk("ws_last_ready", req_ready, 1);
        tick();
        chk("ws_rsp_valid", rsp_valid, 1);
        chk("ws_rsp_err", rsp_err, 0);
        chk("ws_rdata", rsp_rdata, 4'h5);

        // 4: timeout with pready stuck low
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
        pready = 1'b0; prdata = 4'hF;
        tick();
        req_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to_pen%0d", k), penable, 1);
            chk($sformatf("to_norsp%0d", k), rsp_valid, 0);
            chk($sformatf("to_ready%0d", k), req_ready, (k == 3) ? 1 : 0);
            tick();
        end
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rdata_hold", rsp_rdata, 4'h5);
        chk("to_idle_psel", psel, 0);
        tick();
        chk("to_err_clear", rsp_err, 0);
        chk("to_valid_clear", rsp_valid, 0);
        req_valid = 1'b1; req_addr = 2'd0; pready = 1'b1; prdata = 4'h7;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("to_next_valid", rsp_valid, 1);
        chk("to_next_err", rsp_err, 0);
        chk("to_next_rdata", rsp_rdata, 4'h7);

        // 5: reset during ACCESS wait
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; pready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("rm_pen_before", penable, 1);
        prst = 1'b1;
        tick();
        prst = 1'b0;
        chk("rm_psel", psel, 0);
        chk("rm_penable", penable, 0);
        chk("rm_rsp_valid", rsp_valid, 0);
        chk("rm_paddr", paddr, 0);
        chk("rm_pwrite", pwrite, 0);
        chk("rm_rdata", rsp_rdata, 0);
        pready = 1'b1;
        tick();
        chk("rm_no_rsp", rsp_valid, 0);
        chk("rm_idle", psel, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = 4'hC;
        tick();
        chk("rm_next_psel", psel, 1);
        chk("rm_next_pen", penable, 0);
        chk("rm_next_paddr", paddr, 3);
        req_valid = 1'b0;
        tick();
        tick();
        chk("rm_next_rsp", rsp_valid, 1);

        // 6: request inputs change while a transfer is in flight
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 2'd1; req_wdata = 4'h6; pready = 1'b0;
        tick();
        req_addr = 2'd2; req_wdata = 4'h9;
        chk("st_setup_paddr", paddr, 1);
        chk("st_setup_pwdata", pwdata, 4'h6);
        tick();
        req_addr = 2'd3; req_wdata = 4'hB;
        chk("st_acc_paddr", paddr, 1);
        chk("st_acc_pwdata", pwdata, 4'h6);
        tick();
        chk("st_wait_paddr", paddr, 1);
        chk("st_wait_pwdata", pwdata, 4'h6);
        pready = 1'b1;
        tick();
        chk("st_rsp", rsp_valid, 1);
        chk("st_new_paddr", paddr, 3);
        chk("st_new_pwdata", pwdata, 4'hB);
        chk("st_new_setup", penable, 0);
        chk("st_new_psel", psel, 1);
        req_valid = 1'b0;
        tick();
        tick();
        chk("st_final_rsp", rsp_valid, 1);
        tick();
        chk("st_final_idle", psel, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
